burst_read_memory: RTL and testbench
====================================

// Module: burst_read_memory
// PURPOSE
//   Parametrised successor to the async-read Memory: single-clock RAM with a synchronous
//   write port and a registered, burst-streaming read port using valid/ready handshake.
//   Sits between the host loader (writes weights/activations) and the MAC datapath
//   (consumes contiguous words at one per cycle under backpressure).
// PARAMETERS
//   ADDR_WIDTH  8               address bits; storage = 2**ADDR_WIDTH words
//   BIT_SIZE    16              word width in bits
//   LEN_WIDTH   ADDR_WIDTH+1    burst length field width (max burst = 2**ADDR_WIDTH)
// PORTS
//   clk           in   1           clock, all logic on posedge
//   rst_n         in   1           asynchronous, active-low reset
//   write_enable  in   1           write data_in to write_addr this cycle
//   write_addr    in   ADDR_WIDTH  write address
//   data_in       in   BIT_SIZE    write data
//   start         in   1           start-burst pulse, sampled only in IDLE
//   start_addr    in   ADDR_WIDTH  first read address, sampled with start
//   burst_len     in   LEN_WIDTH   number of words, sampled with start
//   out_ready     in   1           consumer accepts data_out this cycle
//   out_valid     out  1           data_out holds a valid word
//   data_out      out  BIT_SIZE    registered read word
//   out_last      out  1           current beat is the last of the burst
//   busy          out  1           state != IDLE
//   done          out  1           one-cycle pulse after burst completes
// BEHAVIOUR
//   Reset (rst_n=0, any time incl. mid-burst): state=IDLE; out_valid, out_last, busy,
//     done = 0; data_out = 0; addr/count regs = 0. RAM array is NOT reset; contents persist.
//   Write: write_enable at posedge stores data_in; independent of FSM state; always accepted.
//   FSM states: IDLE, STREAM, DONE.
//   IDLE: start=1 && burst_len>0 -> STREAM; data_out<=mem[start_addr], out_valid=1
//     next cycle (latency 1), remaining<=burst_len, ptr<=start_addr+1.
//     start=1 && burst_len==0 -> DONE directly; no beat issued.
//   STREAM: beat transfers when out_valid && out_ready.
//     Transfer with remaining>1: data_out<=mem[ptr], ptr++, remaining--, out_valid stays 1
//       (full throughput, one word per cycle).
//     Transfer with remaining==1: out_valid<=0, -> DONE.
//     No transfer (out_ready=0): data_out, out_valid, out_last held stable.
//   out_last = out_valid && remaining==1.
//   DONE: done=1 for exactly this cycle, -> IDLE. busy=1 in STREAM and DONE.
//   start while busy: ignored, no side effects. start in DONE cycle also ignored.
//   Address wrap: ptr increments modulo 2**ADDR_WIDTH (addr 2**ADDR_WIDTH-1 -> 0).
//   Read-during-write, same cycle, same address as the word being loaded into data_out:
//     write-first -- data_out gets data_in. Writes to an address already latched in
//     data_out do not change data_out.
//   burst_len > 2**ADDR_WIDTH is illegal; behaviour is wrap-around re-reading (not checked).
// TESTING
//   1 Write mem[i]=i+100 for i=0..7; start addr=2 len=4, out_ready=1 -> data_out 102,103,
//     104,105 on 4 consecutive cycles starting 1 cycle after start; out_last on 105; done
//     pulses 1 cycle after the final accepted beat.
//   2 Same burst, out_ready toggling 1,0,0,1,... -> each word held stable while ready=0;
//     no word is skipped or duplicated; exactly 4 transfers.
//   3 ADDR_WIDTH=8: start addr=254 len=4 -> reads addr 254,255,0,1 in that order.
//   4 len=0 start -> no out_valid; busy=1 and done=1 on the next cycle only; then IDLE.
//   5 Write-first collision: during a burst, write 0xBEEF to the address being loaded
//     that cycle -> that beat is 0xBEEF; start pulsed mid-burst -> ignored.
//   6 Deassert rst_n mid-burst (ready=0) -> out_valid, busy, done, out_last go 0
//     immediately; after release a new burst returns the pre-reset RAM contents.

Source files
------------

// File: rtl/burst_read_memory.sv
// burst_read_memory
//   Single-clock RAM with a synchronous write port and a registered read port.
//   The read port streams a contiguous burst one word per cycle over a
//   valid/ready handshake. The RAM array is never reset, so its contents
//   survive a reset of the streaming logic.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start; data_out/out_valid idle
//   STREAM | data_out holds a valid beat, waiting for out_ready
//   DONE   | burst finished; done pulses for this single cycle
module burst_read_memory #(
  parameter int ADDR_WIDTH = 8,
  parameter int BIT_SIZE   = 16,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [BIT_SIZE-1:0]   data_in,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [BIT_SIZE-1:0]   data_out,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                 state;
  logic [BIT_SIZE-1:0]    mem [0:DEPTH-1];
  logic [ADDR_WIDTH-1:0]  ptr;
  logic [LEN_WIDTH-1:0]   remaining;
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic [BIT_SIZE-1:0]    rd_data;
  logic                   xfer;

  // Address of the word being loaded into data_out this cycle, with a
  // write-first bypass so a same-cycle write to that address is returned.
  always_comb begin
    rd_addr = (state == IDLE) ? start_addr : ptr;
    if (write_enable && (write_addr == rd_addr)) begin
      rd_data = data_in;
    end else begin
      rd_data = mem[rd_addr];
    end
  end

  assign xfer     = out_valid && out_ready;
  assign out_last = out_valid && (remaining == LEN_WIDTH'(1));

  // Storage write port; always accepted regardless of the burst FSM.
  always_ff @(posedge clk) begin
    if (write_enable) begin
      mem[write_addr] <= data_in;
    end
  end

  // Burst FSM with registered handshake, status and read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (burst_len != '0) begin
              data_out  <= rd_data;
              out_valid <= 1'b1;
              remaining <= burst_len;
              ptr       <= start_addr + ADDR_WIDTH'(1);
              state     <= STREAM;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        STREAM: begin
          if (xfer) begin
            if (remaining > LEN_WIDTH'(1)) begin
              data_out  <= rd_data;
              ptr       <= ptr + ADDR_WIDTH'(1);
              remaining <= remaining - LEN_WIDTH'(1);
            end else begin
              out_valid <= 1'b0;
              remaining <= '0;
              done      <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_burst_read_memory.sv
// Directed testbench for burst_read_memory (ADDR_WIDTH=8, BIT_SIZE=16).
module tb_burst_read_memory;

  logic        clk;
  logic        rst_n;
  logic        write_enable;
  logic [7:0]  write_addr;
  logic [15:0] data_in;
  logic        start;
  logic [7:0]  start_addr;
  logic [8:0]  burst_len;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] data_out;
  logic        out_last;
  logic        busy;
  logic        done;

  int          n_vec;
  int          n_err;
  logic [15:0] exp_w [4];

  burst_read_memory #(.ADDR_WIDTH(8), .BIT_SIZE(16), .LEN_WIDTH(9)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .data_in      (data_in),
    .start        (start),
    .start_addr   (start_addr),
    .burst_len    (burst_len),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .data_out     (data_out),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    write_enable = 1'b1;
    write_addr   = a;
    data_in      = d;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic launch(input logic [7:0] a, input logic [8:0] len);
    start      = 1'b1;
    start_addr = a;
    burst_len  = len;
    tick();
    start      = 1'b0;
  endtask

  // 4-beat burst at full throughput, checked against exp_w
  task automatic burst_full(input string tag, input logic [7:0] a);
    out_ready = 1'b1;
    launch(a, 9'd4);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_data"}, data_out, exp_w[i]);
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_last"}, out_last, (i == 3) ? 1 : 0);
      tick();
    end
    chk({tag, "_valid_end"}, out_valid, 0);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_done"}, busy, 1);
    tick();
    chk({tag, "_done_clr"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    write_enable = 1'b0;
    write_addr = '0;
    data_in = '0;
    start = 1'b0;
    start_addr = '0;
    burst_len = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", data_out, 0);
    #6 rst_n = 1'b1;
    tick();

    // 1: basic burst
    for (int i = 0; i < 8; i++) wr(8'(i), 16'(i + 100));
    exp_w = '{16'd102, 16'd103, 16'd104, 16'd105};
    burst_full("t1", 8'd2);

    // 2: backpressure pattern 1,0,0,1
    out_ready = 1'b1;
    launch(8'd2, 9'd4);
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      out_ready = (c % 4 == 0 || c % 4 == 3);
      chk("t2_valid", out_valid, 1);
      chk(out_ready ? "t2_beat" : "t2_hold", data_out, exp_w[n]);
      chk("t2_last", out_last, (n == 3) ? 1 : 0);
      if (out_ready) n++;
      tick();
    end
    chk("t2_xfers", n, 4);
    chk("t2_valid_end", out_valid, 0);
    chk("t2_done", done, 1);
    tick();
    chk("t2_idle", busy, 0);

    // 3: address wrap 254,255,0,1
    wr(8'd254, 16'h0AFE);
    wr(8'd255, 16'h0AFF);
    exp_w = '{16'h0AFE, 16'h0AFF, 16'd100, 16'd101};
    burst_full("t3", 8'd254);

    // 4: zero-length burst, then start during DONE is ignored
    launch(8'd2, 9'd0);
    chk("t4_valid", out_valid, 0);
    chk("t4_busy", busy, 1);
    chk("t4_done", done, 1);
    launch(8'd2, 9'd2);
    chk("t4_busy_clr", busy, 0);
    chk("t4_done_clr", done, 0);
    chk("t4_no_valid", out_valid, 0);
    tick();
    chk("t4_still_idle", busy, 0);

    // 5: write-first collision and start ignored mid-burst
    out_ready = 1'b1;
    launch(8'd2, 9'd4);
    chk("t5_first", data_out, 16'd102);
    write_enable = 1'b1;
    write_addr   = 8'd3;
    data_in      = 16'hBEEF;
    start        = 1'b1;
    start_addr   = 8'd0;
    burst_len    = 9'd1;
    tick();
    start        = 1'b0;
    chk("t5_collide", data_out, 16'hBEEF);
    out_ready    = 1'b0;
    data_in      = 16'h1234;
    tick();
    write_enable = 1'b0;
    chk("t5_latched", data_out, 16'hBEEF);
    out_ready = 1'b1;
    tick();
    chk("t5_next", data_out, 16'd104);
    tick();
    chk("t5_last_data", data_out, 16'd105);
    chk("t5_last", out_last, 1);
    tick();
    chk("t5_done", done, 1);
    tick();
    chk("t5_idle", busy, 0);

    // 6: reset mid-burst under backpressure
    out_ready = 1'b0;
    launch(8'd2, 9'd4);
    tick();
    chk("t6_pre_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", out_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_last", out_last, 0);
    chk("t6_data", data_out, 0);
    #3 rst_n = 1'b1;
    tick();
    exp_w = '{16'd102, 16'h1234, 16'd104, 16'd105};
    burst_full("t6", 8'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
